// File: rtl/float_round_pkg.sv
// float_round_pkg: shared types and helpers for the float rounding pipeline.
//   rmode_t   - rounding mode encoding. Codes 101..111 are not listed and fall
//               back to round-to-nearest-even.
//   round_up  - decides whether one ulp is added to the truncated mantissa.
package float_round_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rmode_t;

  // l: mantissa LSB, r: round (guard) bit, s: sticky bit, sgn: operand sign
  function automatic logic round_up(input logic l, input logic r, input logic s,
                                    input logic sgn, input rmode_t mode);
    logic up;
    case (mode)
      RNE:     up = r & (s | l);
      RTZ:     up = 1'b0;
      RDN:     up = sgn & (r | s);
      RUP:     up = ~sgn & (r | s);
      RMM:     up = r;
      default: up = r & (s | l);
    endcase
    return up;
  endfunction

endpackage

// File: rtl/float_round_pipe_stage.sv
// float_round_stage: generic valid/ready pipeline register.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   valid_i / ready_o  - upstream handshake; ready_o = ~valid | ready_i
//   data_i             - payload from upstream
//   valid_o / ready_i  - downstream handshake
//   data_o             - registered payload, held while valid_o & ~ready_i
module float_round_stage
  import float_round_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign ready_o = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      // Data only moves with a real transfer, so the last result stays put
      if (valid_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/float_round_pipe.sv
// float_round_pipe: two-stage valid/ready rounding stage placed between the
// normaliser and result packing.
//   Stage 1 registers the incremented mantissa (N+1 bits), sign, exponent,
//   inexact (R|S) and the Inf/NaN marker. Stage 2 registers the resolved
//   mantissa/exponent after carry renormalisation and overflow saturation.
// Ports:
//   clk_i, rst_ni                - clock, asynchronous active-low reset
//   in_valid_i / in_ready_o      - input handshake
//   norm_mant_i, norm_exp_i, sign_i, r_i, s_i, rmode_i - operation
//   out_valid_o / out_ready_i    - output handshake
//   round_mant_o, round_exp_o, round_sign_o, inexact_o, overflow_o - result
//   inexact_cnt_o                - saturating count of inexact results
//                                  (only with FLOAT_ROUND_INEXACT_CNT_EN)
// Build option: define FLOAT_ROUND_INEXACT_CNT_EN to add the inexact counter.
module float_round_pipe
  import float_round_pkg::*;
#(
  parameter int N     = 24,
  parameter int EXP   = 8
`ifdef FLOAT_ROUND_INEXACT_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     norm_mant_i,
  input  logic [EXP-1:0]   norm_exp_i,
  input  logic             sign_i,
  input  logic             r_i,
  input  logic             s_i,
  input  logic [2:0]       rmode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     round_mant_o,
  output logic [EXP-1:0]   round_exp_o,
  output logic             round_sign_o,
  output logic             inexact_o,
  output logic             overflow_o
`ifdef FLOAT_ROUND_INEXACT_CNT_EN
  ,
  output logic [CNT_W-1:0] inexact_cnt_o
`endif
);

  localparam int P1_W = N + 1 + EXP + 3;
  localparam int P2_W = N + EXP + 3;

  // Stage 1 input
  logic            special_d, inex_d, up_d;
  logic [N:0]      sum_d;
  logic [P1_W-1:0] p1_d, p1_q;
  logic            v1_q, rdy2;

  assign special_d = (norm_exp_i == {EXP{1'b1}});
  assign inex_d    = r_i | s_i;
  // Inf/NaN is never incremented, so sum carries the original mantissa through
  assign up_d      = round_up(norm_mant_i[0], r_i, s_i, sign_i, rmode_t'(rmode_i)) & ~special_d;
  assign sum_d     = {1'b0, norm_mant_i} + {{N{1'b0}}, up_d};
  assign p1_d      = {sum_d, norm_exp_i, sign_i, inex_d, special_d};

  float_round_stage #(.W(P1_W)) u_stage1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (in_valid_i),
    .ready_o (in_ready_o),
    .data_i  (p1_d),
    .valid_o (v1_q),
    .ready_i (rdy2),
    .data_o  (p1_q)
  );

  // Stage 2 resolution
  logic [N:0]      s1_sum;
  logic [EXP-1:0]  s1_exp;
  logic            s1_sign, s1_inex, s1_special, carry;
  logic [EXP:0]    exp_ext;
  logic            ovf_d;
  logic [N-1:0]    mant_d;
  logic [EXP-1:0]  exp_d;
  logic            inexact_d;
  logic [P2_W-1:0] p2_d, p2_q;

  assign s1_sum     = p1_q[P1_W-1 -: N+1];
  assign s1_exp     = p1_q[EXP+2:3];
  assign s1_sign    = p1_q[2];
  assign s1_inex    = p1_q[1];
  assign s1_special = p1_q[0];
  assign carry      = s1_sum[N];

  // One extra exponent bit so the increment can never wrap
  assign exp_ext = {1'b0, s1_exp} + {{EXP{1'b0}}, carry};

  always_comb begin
    mant_d    = s1_sum[N-1:0];
    exp_d     = exp_ext[EXP-1:0];
    ovf_d     = 1'b0;
    inexact_d = s1_inex;
    if (s1_special) begin
      exp_d     = s1_exp;
      inexact_d = 1'b0;
    end else begin
      if (carry) mant_d = {1'b1, {(N-1){1'b0}}};
      if (exp_ext == {1'b0, {EXP{1'b1}}}) begin
        ovf_d     = 1'b1;
        mant_d    = {1'b1, {(N-1){1'b0}}};
        exp_d     = {EXP{1'b1}};
        inexact_d = 1'b1;
      end
    end
  end

  assign p2_d = {mant_d, exp_d, s1_sign, inexact_d, ovf_d};

  float_round_stage #(.W(P2_W)) u_stage2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (v1_q),
    .ready_o (rdy2),
    .data_i  (p2_d),
    .valid_o (out_valid_o),
    .ready_i (out_ready_i),
    .data_o  (p2_q)
  );

  assign round_mant_o = p2_q[P2_W-1 -: N];
  assign round_exp_o  = p2_q[EXP+2:3];
  assign round_sign_o = p2_q[2];
  assign inexact_o    = p2_q[1];
  assign overflow_o   = p2_q[0];

`ifdef FLOAT_ROUND_INEXACT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (out_valid_o && out_ready_i && inexact_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign inexact_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_float_round_pipe.sv
// Directed bench for float_round_pipe (N=24, EXP=8).
module tb_float_round_pipe;
  import float_round_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [23:0] norm_mant_i = '0;
  logic [7:0]  norm_exp_i = '0;
  logic        sign_i = 1'b0;
  logic        r_i = 1'b0;
  logic        s_i = 1'b0;
  logic [2:0]  rmode_i = 3'b000;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [23:0] round_mant_o;
  logic [7:0]  round_exp_o;
  logic        round_sign_o;
  logic        inexact_o;
  logic        overflow_o;
`ifdef FLOAT_ROUND_INEXACT_CNT_EN
  logic [15:0] inexact_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  float_round_pipe #(.N(24), .EXP(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .norm_mant_i  (norm_mant_i),
    .norm_exp_i   (norm_exp_i),
    .sign_i       (sign_i),
    .r_i          (r_i),
    .s_i          (s_i),
    .rmode_i      (rmode_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .round_mant_o (round_mant_o),
    .round_exp_o  (round_exp_o),
    .round_sign_o (round_sign_o),
    .inexact_o    (inexact_o),
    .overflow_o   (overflow_o)
`ifdef FLOAT_ROUND_INEXACT_CNT_EN
    ,
    .inexact_cnt_o(inexact_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [23:0] m, input logic [7:0] e, input logic sg,
                       input logic r, input logic s, input rmode_t md);
    norm_mant_i = m;
    norm_exp_i  = e;
    sign_i      = sg;
    r_i         = r;
    s_i         = s;
    rmode_i     = md;
    in_valid_i  = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [23:0] m, input logic [7:0] e,
                         input logic sg, input logic inx, input logic ovf);
    chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
    chk({tag, "_mant"},  {8'd0, round_mant_o}, {8'd0, m});
    chk({tag, "_exp"},   {24'd0, round_exp_o}, {24'd0, e});
    chk({tag, "_sign"},  {31'd0, round_sign_o}, {31'd0, sg});
    chk({tag, "_inex"},  {31'd0, inexact_o}, {31'd0, inx});
    chk({tag, "_ovf"},   {31'd0, overflow_o}, {31'd0, ovf});
  endtask

  // Single operation with out_ready high: offer, then wait (bounded) for result
  task automatic run_op(input string tag, input logic [23:0] m, input logic [7:0] e,
                        input logic sg, input logic r, input logic s, input rmode_t md,
                        input logic [23:0] xm, input logic [7:0] xe,
                        input logic xinx, input logic xovf);
    int cyc;
    @(negedge clk_i);
    drive(m, e, sg, r, s, md);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    cyc = 0;
    while (!out_valid_o && cyc < 10) begin
      @(negedge clk_i);
      cyc++;
    end
    chk_out(tag, xm, xe, sg, xinx, xovf);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_mant", {8'd0, round_mant_o}, 32'd0);
    chk("rst_exp", {24'd0, round_exp_o}, 32'd0);
    chk("rst_flags", {29'd0, round_sign_o, inexact_o, overflow_o}, 32'd0);
    #10 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

    // RNE ties
    run_op("rne_tie_even", 24'h800000, 8'h40, 1'b0, 1'b1, 1'b0, RNE, 24'h800000, 8'h40, 1'b1, 1'b0);
    run_op("rne_tie_odd",  24'h800001, 8'h40, 1'b0, 1'b1, 1'b0, RNE, 24'h800002, 8'h40, 1'b1, 1'b0);
    run_op("rne_exact",    24'h800001, 8'h40, 1'b0, 1'b0, 1'b0, RNE, 24'h800001, 8'h40, 1'b0, 1'b0);
    // Carry renormalisation and overflow
    run_op("carry",        24'hFFFFFF, 8'h80, 1'b0, 1'b1, 1'b0, RNE, 24'h800000, 8'h81, 1'b1, 1'b0);
    run_op("overflow",     24'hFFFFFF, 8'hFE, 1'b0, 1'b1, 1'b0, RNE, 24'h800000, 8'hFF, 1'b1, 1'b1);
    run_op("no_ovf_fe",    24'h900000, 8'hFE, 1'b0, 1'b0, 1'b0, RNE, 24'h900000, 8'hFE, 1'b0, 1'b0);
    // Directed modes, sign=1, R=0, S=1
    run_op("rdn",          24'h800000, 8'h10, 1'b1, 1'b0, 1'b1, RDN, 24'h800001, 8'h10, 1'b1, 1'b0);
    run_op("rup",          24'h800000, 8'h10, 1'b1, 1'b0, 1'b1, RUP, 24'h800000, 8'h10, 1'b1, 1'b0);
    run_op("rtz",          24'h800000, 8'h10, 1'b1, 1'b0, 1'b1, RTZ, 24'h800000, 8'h10, 1'b1, 1'b0);
    run_op("rmm",          24'h800000, 8'h10, 1'b1, 1'b1, 1'b1, RMM, 24'h800001, 8'h10, 1'b1, 1'b0);
    run_op("rup_pos",      24'h800000, 8'h10, 1'b0, 1'b0, 1'b1, RUP, 24'h800001, 8'h10, 1'b1, 1'b0);
    run_op("special",      24'h800000, 8'hFF, 1'b1, 1'b1, 1'b0, RNE, 24'h800000, 8'hFF, 1'b0, 1'b0);
    run_op("special_max",  24'hFFFFFF, 8'hFF, 1'b0, 1'b1, 1'b1, RMM, 24'hFFFFFF, 8'hFF, 1'b0, 1'b0);
    // Reserved mode code behaves as RNE
    @(negedge clk_i);
    drive(24'h800001, 8'h22, 1'b0, 1'b1, 1'b0, RNE);
    rmode_i = 3'b111;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk_out("rsvd_mode", 24'h800002, 8'h22, 1'b0, 1'b1, 1'b0);

    // Backpressure: A, B accepted, C held until release
    @(negedge clk_i);
    out_ready_i = 1'b0;
    drive(24'h800001, 8'h10, 1'b0, 1'b1, 1'b0, RNE);          // A
    @(negedge clk_i);
    chk("bp_ready_b", {31'd0, in_ready_o}, 32'd1);
    drive(24'h923456, 8'h20, 1'b1, 1'b0, 1'b0, RTZ);          // B
    @(negedge clk_i);
    chk_out("bp_a0", 24'h800002, 8'h10, 1'b0, 1'b1, 1'b0);
    chk("bp_stall0", {31'd0, in_ready_o}, 32'd0);
    drive(24'hFFFFFF, 8'h30, 1'b0, 1'b0, 1'b1, RUP);          // C
    @(negedge clk_i);
    chk_out("bp_a1", 24'h800002, 8'h10, 1'b0, 1'b1, 1'b0);
    chk("bp_stall1", {31'd0, in_ready_o}, 32'd0);
    @(negedge clk_i);
    chk_out("bp_a2", 24'h800002, 8'h10, 1'b0, 1'b1, 1'b0);
    chk("bp_stall2", {31'd0, in_ready_o}, 32'd0);
    out_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready_o}, 32'd1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk_out("bp_b", 24'h923456, 8'h20, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    chk_out("bp_c", 24'h800000, 8'h31, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("bp_drained", {31'd0, out_valid_o}, 32'd0);

    // Reset with two operations buffered
    out_ready_i = 1'b0;
    drive(24'h800001, 8'h50, 1'b1, 1'b1, 1'b1, RNE);
    @(negedge clk_i);
    drive(24'hFFFFFF, 8'hFE, 1'b0, 1'b1, 1'b0, RNE);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("mid_valid_before", {31'd0, out_valid_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("mid_rst_mant", {8'd0, round_mant_o}, 32'd0);
    chk("mid_rst_exp", {24'd0, round_exp_o}, 32'd0);
    chk("mid_rst_flags", {29'd0, round_sign_o, inexact_o, overflow_o}, 32'd0);
`ifdef FLOAT_ROUND_INEXACT_CNT_EN
    chk("mid_rst_cnt", {16'd0, inexact_cnt_o}, 32'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    chk("post_rst_ready", {31'd0, in_ready_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("post_rst_no_stale", {31'd0, out_valid_o}, 32'd0);
    end

`ifdef FLOAT_ROUND_INEXACT_CNT_EN
    // Two inexact results and one exact result -> count of 2
    run_op("cnt_op1", 24'h800000, 8'h10, 1'b0, 1'b1, 1'b0, RNE, 24'h800000, 8'h10, 1'b1, 1'b0);
    run_op("cnt_op2", 24'h800000, 8'h10, 1'b0, 1'b0, 1'b0, RNE, 24'h800000, 8'h10, 1'b0, 1'b0);
    run_op("cnt_op3", 24'h800000, 8'h10, 1'b0, 1'b0, 1'b1, RUP, 24'h800001, 8'h10, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("cnt_value", {16'd0, inexact_cnt_o}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_round_pipe.md
Name: float_round_pipe

Overview:
- Parametrised successor to the single-cycle float rounding stage.
- Takes a normalised mantissa (hidden bit at MSB), exponent, sign, round (R) and sticky (S) bits, plus a per-operation rounding mode.
- Produces the rounded mantissa/exponent, with mantissa-carry renormalisation, exponent overflow detection and IEEE-style flags.
- Two-stage valid/ready pipeline; sits after the normaliser and before result packing in the FP datapath.

Parameters:
- N, 24, mantissa width including hidden bit.
- EXP, 8, exponent width.
- CNT_W, 16, inexact event counter width (optional feature only).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  input operation valid.
- in_ready  output  1  pipeline can accept input this cycle.
- normMant  input  N  normalised mantissa.
- normExp  input  EXP  biased exponent.
- sign  input  1  operand sign.
- R  input  1  round (guard) bit.
- S  input  1  sticky bit.
- rmode  input  3  rounding mode.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- roundMant  output  N  rounded mantissa.
- roundExp  output  EXP  rounded exponent.
- roundSign  output  1  sign passthrough.
- inexact  output  1  result inexact.
- overflow  output  1  exponent overflow.

Behaviour:
- Reset (Reset=0, asynchronous): all stage registers and outputs clear to 0, including out_valid, roundMant, roundExp, roundSign, inexact and overflow. In-flight operations are discarded. in_ready=1 once reset deasserts.
- Handshake:
  - Transfer on valid&ready at each boundary.
  - Stage k holds data while valid_k & ~ready_(k+1).
  - ready_k = ~valid_k | ready_(k+1); in_ready = ready_1 (combinational from out_ready).
  - Latency: 2 cycles with no stall; throughput: 1 per cycle.
  - Up to 2 operations buffered; order preserved, no drop or duplication.
  - Held outputs remain stable while out_valid & ~out_ready.
- rmode encoding and round-up condition (L = normMant[0]):
  - 000 RNE: R&(S|L).
  - 001 RTZ: 0.
  - 010 RDN: sign&(R|S).
  - 011 RUP: ~sign&(R|S).
  - 100 RMM: R.
  - 101..111: treated as RNE.
- Stage 1 registers:
  - sum = {1'b0,normMant} + up, width N+1.
  - sign, exp.
  - inex = R|S.
  - special = (normExp == all ones).
- Stage 2 resolution:
  - special: roundMant=normMant, roundExp=normExp, inexact=0, overflow=0 (Inf/NaN passthrough, no rounding).
  - sum[N]=1 (carry): roundMant = {1'b1, {N-1{0}}}, exp+1.
  - Otherwise roundMant = sum[N-1:0], exp unchanged.
  - If the resulting exponent equals all ones: overflow=1, roundExp=all ones, roundMant={1'b1,0...}.
  - inexact = inex | overflow (for non-special operations).
- Exponent arithmetic is EXP+1 wide internally; there is no wrap-around.

Optional Feature:
- Macro: FLOAT_ROUND_INEXACT_CNT_EN.
- Defined:
  - Adds output port inexact_cnt [CNT_W-1:0], reset to 0.
  - Increments on each output handshake (out_valid&out_ready) with inexact=1.
  - Saturates at all ones.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package float_round_pkg holds:
  - typedef enum logic [2:0] rmode_t (RNE, RTZ, RDN, RUP, RMM).
  - The round-up decision function round_up(L,R,S,sign,mode).
- One sub-module: float_round_stage, a generic valid/ready pipeline register parametrised by payload width, instantiated twice.

Test Plan:
1. RNE ties (N=24, EXP=8):
   - normMant=0x800000, R=1, S=0 -> roundMant=0x800000, inexact=1.
   - normMant=0x800001, R=1, S=0 -> roundMant=0x800002.
2. Carry renormalisation: normMant=0xFFFFFF, normExp=0x80, R=1, RNE -> roundMant=0x800000, roundExp=0x81, overflow=0.
3. Overflow: normMant=0xFFFFFF, normExp=0xFE, R=1, RNE -> roundExp=0xFF, roundMant=0x800000, overflow=1, inexact=1.
4. Directed modes: sign=1, R=0, S=1, normMant=0x800000:
   - RDN -> 0x800001.
   - RUP -> 0x800000.
   - RTZ -> 0x800000.
   - RMM with R=1 -> 0x800001.
   - normExp=0xFF with R=1 -> passthrough, flags 0.
5. Backpressure:
   - Stimulus: out_ready=0 for 4 cycles while inputs A,B,C are offered back-to-back.
   - Response: A and B accepted, then in_ready=0; C is held at the input.
   - On release: out_valid results in order A,B,C, one per cycle; outputs stable during stall.
6. Reset mid-flight: Reset=0 asynchronously with 2 operations buffered -> out_valid=0 immediately, all outputs 0, no stale result after release; inexact_cnt=0 when FLOAT_ROUND_INEXACT_CNT_EN is defined.
